// File: rtl/pipe_seq_ctrl.sv
// Frame sequencer and valid/sof/eof aligner for a LATENCY-deep register-chain datapath.
// Optional overrun detection is built when PIPE_SEQ_CTRL_OVERRUN_CHK_EN is defined.
module pipe_seq_ctrl #(
   parameter int LATENCY   = 4,
   parameter int FRAME_LEN = 1024,
   parameter int CNT_W     = 16
) (
   input  logic             CLK_in,
   input  logic             RST_in,
   input  logic             start_in,
   input  logic             abort_in,
   input  logic             in_valid_in,
   output logic             in_ready_out,
   output logic             out_valid_out,
   output logic             out_sof_out,
   output logic             out_eof_out,
   output logic             busy_out,
   output logic             done_out,
   output logic [CNT_W-1:0] pix_cnt_out,
   output logic             err_out
);

   localparam int DRN_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   issue_q, issue_d;
   logic [DRN_W-1:0]   drain_q, drain_d;
   logic [CNT_W-1:0]   pix_q;
   logic [LATENCY-1:0] vld_q, sof_q, eof_q;
   logic               push_vld_s, push_sof_s, push_eof_s;
   logic               start_ok_s;

   // Next-state, counter and shadow-push decode; abort overrides everything
   always_comb begin
      state_d    = state_q;
      issue_d    = issue_q;
      drain_d    = drain_q;
      push_vld_s = 1'b0;
      push_sof_s = 1'b0;
      push_eof_s = 1'b0;
      start_ok_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d    = S_RUN;
               issue_d    = '0;
               start_ok_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (in_valid_in) begin
               push_vld_s = 1'b1;
               push_sof_s = (issue_q == '0);
               push_eof_s = (issue_q == LAST_IDX);
               issue_d    = issue_q + CNT_W'(1);
               if (issue_q == LAST_IDX) begin
                  state_d = S_DRAIN;
                  drain_d = DRN_LOAD;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            // Counter holds the cycles still left before the eof reaches the output
            if (drain_q <= DRN_W'(1)) begin
               state_d = S_DONE;
               drain_d = '0;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort_in) begin
         state_d    = S_IDLE;
         issue_d    = '0;
         drain_d    = '0;
         push_vld_s = 1'b0;
         push_sof_s = 1'b0;
         push_eof_s = 1'b0;
         start_ok_s = 1'b0;
      end else begin
         start_ok_s = start_ok_s;
      end
   end

   // State, counters and state-decoded outputs, registered from next state
   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         state_q      <= S_IDLE;
         issue_q      <= '0;
         drain_q      <= '0;
         in_ready_out <= 1'b0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
      end else begin
         state_q      <= state_d;
         issue_q      <= issue_d;
         drain_q      <= drain_d;
         in_ready_out <= (state_d == S_RUN);
         busy_out     <= (state_d == S_RUN) || (state_d == S_DRAIN);
         done_out     <= (state_d == S_DONE);
      end
   end

   // Shadow pipeline mirroring the datapath register chain
   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         vld_q <= '0;
         sof_q <= '0;
         eof_q <= '0;
      end else if (abort_in) begin
         vld_q <= '0;
         sof_q <= '0;
         eof_q <= '0;
      end else begin
         vld_q[0] <= push_vld_s;
         sof_q[0] <= push_sof_s;
         eof_q[0] <= push_eof_s;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            sof_q[i] <= sof_q[i-1];
            eof_q[i] <= eof_q[i-1];
         end
      end
   end

   assign out_valid_out = vld_q[LATENCY-1];
   assign out_sof_out   = sof_q[LATENCY-1];
   assign out_eof_out   = eof_q[LATENCY-1];

   // Saturating count of samples emitted in the current frame
   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         pix_q <= '0;
      end else if (start_ok_s) begin
         pix_q <= '0;
      end else if (vld_q[LATENCY-1] && (pix_q != '1)) begin
         pix_q <= pix_q + CNT_W'(1);
      end else begin
         pix_q <= pix_q;
      end
   end

   assign pix_cnt_out = pix_q;

`ifdef PIPE_SEQ_CTRL_OVERRUN_CHK_EN
   logic err_q;
   logic ovr_s;

   assign ovr_s = in_valid_in && ((state_q == S_DRAIN) || (state_q == S_DONE));

   // Sticky overrun flag, cleared only by an honoured start
   always_ff @(posedge CLK_in or posedge RST_in) begin
      if (RST_in) begin
         err_q <= 1'b0;
      end else if (start_ok_s) begin
         err_q <= 1'b0;
      end else if (ovr_s) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign err_out = err_q;
`else
   assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: timestamp-based reference model of frames,
// plus a directed check of a LATENCY=1, FRAME_LEN=1 instance.
module tb_pipe_seq_ctrl;

   localparam int L = 4;
   localparam int F = 8;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst, start, abort, valid;
   logic         ready, ov, sof, eof, busy, done, err;
   logic [W-1:0] pix;

   logic         s1_start, s1_valid;
   logic         o1_ready, o1_valid, o1_sof, o1_eof, o1_busy, o1_done, o1_err;
   logic [3:0]   o1_pix;

   always #5 clk = ~clk;

   pipe_seq_ctrl #(.LATENCY(L), .FRAME_LEN(F), .CNT_W(W)) dut (
      .CLK_in(clk), .RST_in(rst), .start_in(start), .abort_in(abort),
      .in_valid_in(valid), .in_ready_out(ready), .out_valid_out(ov),
      .out_sof_out(sof), .out_eof_out(eof), .busy_out(busy), .done_out(done),
      .pix_cnt_out(pix), .err_out(err)
   );

   pipe_seq_ctrl #(.LATENCY(1), .FRAME_LEN(1), .CNT_W(4)) u1 (
      .CLK_in(clk), .RST_in(rst), .start_in(s1_start), .abort_in(1'b0),
      .in_valid_in(s1_valid), .in_ready_out(o1_ready), .out_valid_out(o1_valid),
      .out_sof_out(o1_sof), .out_eof_out(o1_eof), .busy_out(o1_busy), .done_out(o1_done),
      .pix_cnt_out(o1_pix), .err_out(o1_err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: a frame is its start cycle, the list of accept cycles and an abort cycle
   bit started = 1'b0;
   int t0      = 0;
   int acc[$];
   bit aborted = 1'b0;
   int abort_c = 0;
   bit err_m   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit full_m();
      return acc.size() == F;
   endfunction

   function automatic bit killed(int k);
      return aborted && (k > abort_c);
   endfunction

   function automatic bit ready_m(int k);
      return started && (k > t0) && !killed(k) && !full_m();
   endfunction

   function automatic bit busy_m(int k);
      return started && (k > t0) && !killed(k) && (!full_m() || (k <= acc[F-1] + L));
   endfunction

   function automatic bit done_m(int k);
      return started && full_m() && !killed(k) && (k == acc[F-1] + L + 1);
   endfunction

   function automatic bit idle_m(int k);
      return !started || (k <= t0) || killed(k) || (full_m() && (k > acc[F-1] + L + 1));
   endfunction

   function automatic bit drain_done_m(int k);
      return started && full_m() && !killed(k) && (k > acc[F-1]) && (k <= acc[F-1] + L + 1);
   endfunction

   // Expected output markers and count: sample i leaves L cycles after its accept unless squashed
   function automatic void outs_m(input int k, output bit v, output bit s, output bit e, output int p);
      v = 1'b0; s = 1'b0; e = 1'b0; p = 0;
      foreach (acc[i]) begin
         int x;
         x = acc[i] + L;
         if (aborted && (x > abort_c)) continue;
         if (x == k) begin
            v = 1'b1;
            if (i == 0) s = 1'b1;
            if (i == F - 1) e = 1'b1;
         end
         if (x < k) p++;
      end
   endfunction

   task automatic check_all();
      bit v, s, e;
      int p;
      outs_m(cyc, v, s, e, p);
      chk("ready", 32'(ready), 32'(ready_m(cyc)));
      chk("out_valid", 32'(ov), 32'(v));
      chk("out_sof", 32'(sof), 32'(s));
      chk("out_eof", 32'(eof), 32'(e));
      chk("busy", 32'(busy), 32'(busy_m(cyc)));
      chk("done", 32'(done), 32'(done_m(cyc)));
      chk("pix_cnt", 32'(pix), 32'(p));
      chk("err", 32'(err), 32'(err_m));
   endtask

   task automatic step(input bit st, input bit ab, input bit vl);
      int k;
      bit acc_now, dd, hon, ab_eff;
      k       = cyc;
      start   = st;
      abort   = ab;
      valid   = vl;
      acc_now = ready_m(k) && vl && !ab;
      dd      = drain_done_m(k);
      hon     = st && !ab && idle_m(k);
      ab_eff  = ab && !idle_m(k);
      if (acc_now) acc.push_back(k);
`ifdef PIPE_SEQ_CTRL_OVERRUN_CHK_EN
      if (hon) err_m = 1'b0;
      else if (vl && dd) err_m = 1'b1;
`endif
      if (ab_eff) begin
         aborted = 1'b1;
         abort_c = k;
      end
      if (hon) begin
         started = 1'b1;
         t0      = k;
         acc.delete();
         aborted = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
      check_all();
   endtask

   task automatic mid_reset();
      rst = 1'b1;
      #1;
      started = 1'b0;
      acc.delete();
      aborted = 1'b0;
      err_m   = 1'b0;
      check_all();
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      check_all();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0;
      s1_start = 1'b0; s1_valid = 1'b0;
      @(posedge clk);
      #1;
      check_all();
      chk("u1_reset_valid", 32'(o1_valid), 32'd0);
      chk("u1_reset_ready", 32'(o1_ready), 32'd0);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Frame with valid held: back-to-back accepts, then overrun in DRAIN/DONE/IDLE
      step(1'b1, 1'b0, 1'b0);
      repeat (20) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Toggling valid, with start pulses landing in RUN and in DRAIN
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30; i++) step((i == 5) || (i == 17), 1'b0, (i % 2) == 0);

      // Random valid, abort in the third DRAIN cycle
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         bit ab;
         ab = full_m() && !aborted && (cyc == acc[F-1] + 3);
         step(1'b0, ab, 1'($urandom_range(0, 1)));
      end

      // Clean frame after the abort
      step(1'b1, 1'b0, 1'b0);
      repeat (40) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

      // Abort and start together in IDLE: stays IDLE
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // Random mix of starts, aborts and valids
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)));
      repeat (16) step(1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a frame, then a fresh frame
      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b1);
      mid_reset();
      step(1'b1, 1'b0, 1'b0);
      repeat (16) step(1'b0, 1'b0, 1'b1);

      // LATENCY=1, FRAME_LEN=1 instance: start at t, accept at t+1, outputs t+2, done t+3
      s1_start = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      chk("u1_ready_t1", 32'(o1_ready), 32'd1);
      chk("u1_busy_t1", 32'(o1_busy), 32'd1);
      s1_start = 1'b0;
      s1_valid = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      s1_valid = 1'b0;
      chk("u1_valid_t2", 32'(o1_valid), 32'd1);
      chk("u1_sof_t2", 32'(o1_sof), 32'd1);
      chk("u1_eof_t2", 32'(o1_eof), 32'd1);
      chk("u1_ready_t2", 32'(o1_ready), 32'd0);
      chk("u1_done_t2", 32'(o1_done), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("u1_done_t3", 32'(o1_done), 32'd1);
      chk("u1_valid_t3", 32'(o1_valid), 32'd0);
      chk("u1_pix_t3", 32'(o1_pix), 32'd1);
      chk("u1_busy_t3", 32'(o1_busy), 32'd0);
      chk("u1_err", 32'(o1_err), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("u1_done_t4", 32'(o1_done), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
